pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 73 +++++++
 tb/tb_pc_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with branch/call/return/interrupt and a wrapping return-address stack
module pc_sequencer #(
  parameter int ADDR_W = 10,
  parameter int RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] IRQ_VEC = ADDR_W'('h3F0)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           branch,
  input  logic [ADDR_W-1:0]              branch_address,
  input  logic                           call,
  input  logic [ADDR_W-1:0]              call_address,
  input  logic                           ret,
  input  logic                           irq,
  input  logic                           err_clr,
  output logic [ADDR_W-1:0]              pc,
  output logic                           irq_ack,
  output logic [$clog2(RAS_DEPTH):0]     ras_count,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] stack [RAS_DEPTH];
  logic [PW-1:0] wp;
  logic do_irq, do_ret, do_call, do_branch, full, empty, push, pop, over, under;
  logic [ADDR_W-1:0] pc_inc, top, push_data, pc_next;
  // decode the single winning action; the stack is a circular buffer so a full push overwrites the oldest entry
  always_comb begin
    do_irq = ~stall & irq;
    do_ret = ~stall & ~irq & ret;
    do_call = ~stall & ~irq & ~ret & call;
    do_branch = ~stall & ~irq & ~ret & ~call & branch;
    full = ras_count == CW'(RAS_DEPTH);
    empty = ras_count == '0;
    push = do_irq | do_call;
    pop = do_ret & ~empty;
    over = push & full;
    under = do_ret & empty;
    pc_inc = pc + ADDR_W'(1);
    top = stack[wp - PW'(1)];
    push_data = do_irq ? pc : pc_inc;
    pc_next = stall ? pc :
              do_irq ? IRQ_VEC :
              pop ? top :
              do_call ? call_address :
              do_branch ? branch_address : pc_inc;
  end
  // stack storage is deliberately not reset; it is unreadable while empty
  always_ff @(posedge clk) begin
    if (push) stack[wp] <= push_data;
  end
  // pc, stack bookkeeping and sticky flags; a new error beats a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_VEC;
      irq_ack <= 1'b0;
      ras_count <= '0;
      wp <= '0;
      ras_overflow <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc <= pc_next;
      irq_ack <= do_irq;
      ras_count <= (push & ~full) ? ras_count + CW'(1) : pop ? ras_count - CW'(1) : ras_count;
      wp <= push ? wp + PW'(1) : pop ? wp - PW'(1) : wp;
      ras_overflow <= over | (ras_overflow & ~err_clr);
      ras_underflow <= under | (ras_underflow & ~err_clr);
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic reset, stall, branch, call, ret, irq, err_clr;
  logic [9:0] branch_address, call_address, pc;
  logic irq_ack, ras_overflow, ras_underflow;
  logic [2:0] ras_count;
  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .branch_address(branch_address),
    .call(call), .call_address(call_address), .ret(ret), .irq(irq), .err_clr(err_clr),
    .pc(pc), .irq_ack(irq_ack), .ras_count(ras_count), .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout pc=%h", pc);
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    stall = 0; branch = 0; call = 0; ret = 0; irq = 0; err_clr = 0;
  endtask

  task automatic goto(input logic [9:0] a);
    branch = 1; branch_address = a;
    tick();
    branch = 0;
  endtask

  task automatic test_reset;
    reset = 1; idle(); branch_address = '0; call_address = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pc !== 10'h000) begin errors++; $display("FAIL reset_pc got %h exp 000", pc); end
    checks++; if (irq_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", irq_ack); end
    checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", ras_count); end
    checks++; if ({ras_overflow, ras_underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {ras_overflow, ras_underflow}); end
    reset = 0;
  endtask

  task automatic test_increment;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if (pc !== 10'(i)) begin errors++; $display("FAIL inc_%0d got %h exp %h", i, pc, 10'(i)); end
    end
    goto(10'h3FF);
    checks++; if (pc !== 10'h3FF) begin errors++; $display("FAIL branch_3ff got %h exp 3ff", pc); end
    tick();
    checks++; if (pc !== 10'h000) begin errors++; $display("FAIL wrap got %h exp 000", pc); end
    checks++; if ({ras_overflow, ras_underflow} !== 2'b00) begin errors++; $display("FAIL wrap_flags got %b exp 00", {ras_overflow, ras_underflow}); end
  endtask

  task automatic test_call_ret;
    goto(10'h010);
    call = 1; call_address = 10'h200;
    tick();
    call = 0;
    checks++; if (pc !== 10'h200) begin errors++; $display("FAIL call_pc got %h exp 200", pc); end
    checks++; if (ras_count !== 3'd1) begin errors++; $display("FAIL call_count got %0d exp 1", ras_count); end
    tick();
    checks++; if (pc !== 10'h201) begin errors++; $display("FAIL call_inc1 got %h exp 201", pc); end
    tick();
    checks++; if (pc !== 10'h202) begin errors++; $display("FAIL call_inc2 got %h exp 202", pc); end
    ret = 1;
    tick();
    ret = 0;
    checks++; if (pc !== 10'h011) begin errors++; $display("FAIL ret_pc got %h exp 011", pc); end
    checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL ret_count got %0d exp 0", ras_count); end
  endtask

  task automatic test_nested;
    logic [9:0] tgt [5] = '{10'h100, 10'h110, 10'h120, 10'h130, 10'h140};
    logic [9:0] rpc [4] = '{10'h131, 10'h121, 10'h111, 10'h101};
    goto(10'h000);
    call = 1;
    for (int i = 0; i < 5; i++) begin
      call_address = tgt[i];
      tick();
      checks++; if (pc !== tgt[i]) begin errors++; $display("FAIL nest_call_%0d got %h exp %h", i, pc, tgt[i]); end
    end
    call = 0;
    checks++; if (ras_count !== 3'd4) begin errors++; $display("FAIL nest_full got %0d exp 4", ras_count); end
    checks++; if (ras_overflow !== 1'b1) begin errors++; $display("FAIL nest_ovf got %b exp 1", ras_overflow); end
    ret = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (pc !== rpc[i]) begin errors++; $display("FAIL nest_ret_%0d got %h exp %h", i, pc, rpc[i]); end
    end
    tick();
    ret = 0;
    checks++; if (pc !== 10'h102) begin errors++; $display("FAIL nest_under_pc got %h exp 102", pc); end
    checks++; if ({ras_overflow, ras_underflow} !== 2'b11) begin errors++; $display("FAIL nest_flags got %b exp 11", {ras_overflow, ras_underflow}); end
    checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL nest_count got %0d exp 0", ras_count); end
  endtask

  task automatic test_err_clr;
    err_clr = 1; ret = 1;
    tick();
    ret = 0;
    checks++; if (ras_underflow !== 1'b1) begin errors++; $display("FAIL clr_race_unf got %b exp 1", ras_underflow); end
    checks++; if (ras_overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf got %b exp 0", ras_overflow); end
    checks++; if (pc !== 10'h103) begin errors++; $display("FAIL clr_pc got %h exp 103", pc); end
    tick();
    err_clr = 0;
    checks++; if (ras_underflow !== 1'b0) begin errors++; $display("FAIL clr_unf got %b exp 0", ras_underflow); end
  endtask

  task automatic test_irq;
    goto(10'h050);
    irq = 1; call = 1; call_address = 10'h222; branch = 1; branch_address = 10'h333;
    tick();
    idle();
    checks++; if (pc !== 10'h3F0) begin errors++; $display("FAIL irq_pc got %h exp 3f0", pc); end
    checks++; if (irq_ack !== 1'b1) begin errors++; $display("FAIL irq_ack got %b exp 1", irq_ack); end
    checks++; if (ras_count !== 3'd1) begin errors++; $display("FAIL irq_count got %0d exp 1", ras_count); end
    tick();
    checks++; if (irq_ack !== 1'b0) begin errors++; $display("FAIL irq_ack_pulse got %b exp 0", irq_ack); end
    checks++; if (pc !== 10'h3F1) begin errors++; $display("FAIL irq_inc got %h exp 3f1", pc); end
    ret = 1;
    tick();
    ret = 0;
    checks++; if (pc !== 10'h050) begin errors++; $display("FAIL irq_ret got %h exp 050", pc); end
  endtask

  task automatic test_stall;
    ret = 1;
    tick();
    ret = 0;
    checks++; if (ras_underflow !== 1'b1) begin errors++; $display("FAIL stall_setup_unf got %b exp 1", ras_underflow); end
    stall = 1; branch = 1; branch_address = 10'h123; err_clr = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      err_clr = 0;
      checks++; if (pc !== 10'h051) begin errors++; $display("FAIL stall_hold_%0d got %h exp 051", i, pc); end
    end
    checks++; if (ras_underflow !== 1'b0) begin errors++; $display("FAIL stall_clr got %b exp 0", ras_underflow); end
    idle();
    tick();
    checks++; if (pc !== 10'h052) begin errors++; $display("FAIL stall_release got %h exp 052", pc); end
  endtask

  task automatic test_irq_level;
    irq = 1;
    tick();
    checks++; if (pc !== 10'h3F0 || irq_ack !== 1'b1) begin errors++; $display("FAIL lvl1 got %h/%b exp 3f0/1", pc, irq_ack); end
    tick();
    checks++; if (irq_ack !== 1'b1 || ras_count !== 3'd2) begin errors++; $display("FAIL lvl2 got %b/%0d exp 1/2", irq_ack, ras_count); end
    stall = 1;
    tick();
    checks++; if (pc !== 10'h3F0 || irq_ack !== 1'b0 || ras_count !== 3'd2) begin errors++; $display("FAIL lvl_stall got %h/%b/%0d exp 3f0/0/2", pc, irq_ack, ras_count); end
    idle();
    tick();
    checks++; if (pc !== 10'h3F1 || irq_ack !== 1'b0) begin errors++; $display("FAIL lvl_drop got %h/%b exp 3f1/0", pc, irq_ack); end
    ret = 1;
    tick();
    checks++; if (pc !== 10'h3F0 || ras_count !== 3'd1) begin errors++; $display("FAIL lvl_ret1 got %h/%0d exp 3f0/1", pc, ras_count); end
    tick();
    ret = 0;
    checks++; if (pc !== 10'h052 || ras_count !== 3'd0) begin errors++; $display("FAIL lvl_ret2 got %h/%0d exp 052/0", pc, ras_count); end
  endtask

  task automatic test_reset_mid;
    irq = 1; call = 1; call_address = 10'h044;
    #2;
    reset = 1;
    #1;
    checks++; if (pc !== 10'h000 || irq_ack !== 1'b0) begin errors++; $display("FAIL async_reset got %h/%b exp 000/0", pc, irq_ack); end
    tick();
    idle();
    reset = 0;
    tick();
    checks++; if (pc !== 10'h001 || ras_count !== 3'd0 || irq_ack !== 1'b0) begin errors++; $display("FAIL post_reset got %h/%0d/%b exp 001/0/0", pc, ras_count, irq_ack); end
  endtask

  initial begin
    test_reset();
    test_increment();
    test_call_ret();
    test_nested();
    test_err_clr();
    test_irq();
    test_stall();
    test_irq_level();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
